// File: rtl/mul64_sequencer.sv
// Sequencer for the iterative shift-add long multiply (UMULL/SMULL): latches operands on start,
// iterates over the multiplier bits, applies the sign, then writes back RdLo followed by RdHi.
module mul64_sequencer #(
   parameter int WIDTH     = 32,
   parameter bit EARLY_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             wb_en,
   output logic             wb_sel,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      WBLO = 3'd4,
      WBHI = 3'd5
   } state_t;

   state_t             state, state_nxt;
   logic               sgn_q, neg_q;
   logic [WIDTH-1:0]   a_q, b_q, mplier;
   logic [2*WIDTH-1:0] mcand, acc;
   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   mplier_shift;
   logic               iter_last;

   // The most negative operand maps to its own bit pattern, read as an unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic neg);
      return neg ? (~v + ONE) : v;
   endfunction

   assign mplier_shift = mplier >> 1;
   assign iter_last    = (count == CW'(WIDTH-1)) || (EARLY_OUT && (mplier_shift == '0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = IDLE;
      if (!flush) begin
         case (state)
            IDLE:    state_nxt = start ? PREP : IDLE;
            PREP:    state_nxt = ITER;
            ITER:    state_nxt = iter_last ? FIX : ITER;
            FIX:     state_nxt = WBLO;
            WBLO:    state_nxt = WBHI;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      busy   = (state != IDLE);
      wb_en  = 1'b0;
      wb_sel = 1'b0;
      done   = 1'b0;
      case (state)
         WBLO: wb_en = !flush;
         WBHI: begin
            wb_en  = !flush;
            wb_sel = 1'b1;
            done   = !flush;
         end
         default: ;
      endcase
   end

   // Datapath: a flush freezes everything, so results survive an aborted multiply.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sgn_q     <= 1'b0;
         neg_q     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         count     <= '0;
         result_lo <= '0;
         result_hi <= '0;
      end else if (!flush) begin
         case (state)
            IDLE: if (start) begin
               sgn_q <= is_signed;
               a_q   <= op_a;
               b_q   <= op_b;
            end
            PREP: begin
               mcand  <= {{WIDTH{1'b0}}, magnitude(a_q, sgn_q)};
               mplier <= magnitude(b_q, sgn_q);
               neg_q  <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               acc    <= '0;
               count  <= '0;
            end
            ITER: begin
               if (mplier[0]) acc <= acc + (mcand << count);
               mplier <= mplier_shift;
               count  <= count + CW'(1);
            end
            FIX: {result_hi, result_lo} <= apply_sign(acc, neg_q);
            default: ;
         endcase
      end
   end

endmodule
